// File: rtl/pci_conf_cyc_addr_dec_pipe.sv
// rtl/pci_conf_cyc_addr_dec_pipe.sv - buffered PCI configuration-cycle address decoder with IDSEL one-hot translation
//
// Type 0 addresses get their device number (bits 15:11) turned into a one-hot
// IDSEL bit at IDSEL_LO+d. Type 1 addresses pass straight through.
// Decoded entries are queued in a DEPTH-entry circular FIFO toward the PCI master.
// Device numbers with no IDSEL line are flagged as master-abort candidates.
// Optional feature macro: CCYC_DEC_ABORT_CNT_EN adds a saturating abort counter
// (abort_cnt_out) with a synchronous clear (abort_cnt_clr_in).

module pci_conf_cyc_addr_dec_pipe #(
   parameter int IDSEL_LO = 11,
   parameter int NUM_DEV  = 21,
   parameter int DEPTH    = 4,
   parameter int CNT_W    = 16
) (
   input  logic                     clk_in,
   input  logic                     reset_n_in,
   input  logic                     flush_in,
   input  logic                     in_valid_in,
   output logic                     in_ready_out,
   input  logic [31:0]              ccyc_addr_in,
   output logic                     out_valid_out,
   input  logic                     out_ready_in,
   output logic [31:0]              ccyc_addr_out,
   output logic                     out_type1_out,
   output logic                     out_abort_out,
   output logic [$clog2(DEPTH):0]   level_out
`ifdef CCYC_DEC_ABORT_CNT_EN
   ,
   output logic [CNT_W-1:0]         abort_cnt_out,
   input  logic                     abort_cnt_clr_in
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   // Parameter legality: a bad configuration stops elaboration instead of
   // silently producing a decoder with overlapping or missing IDSEL lines.
   if (IDSEL_LO < 3 || IDSEL_LO > 31) begin : g_bad_idsel_lo
      $error("IDSEL_LO must be in 3..31");
   end
   if (NUM_DEV < 1 || NUM_DEV > (32 - IDSEL_LO)) begin : g_bad_num_dev
      $error("NUM_DEV must be in 1..(32-IDSEL_LO)");
   end
   if (DEPTH < 2 || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("DEPTH must be a power of two and at least 2");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
   end

   // ------------------------------------------------------------------
   // Input-side decode
   // ------------------------------------------------------------------
   logic [4:0]  dev;
   logic [31:0] dec_addr;
   logic        dec_type1;
   logic        dec_abort;

   // Translate the raw configuration address into its bus form.
   always_comb begin
      dev       = ccyc_addr_in[15:11];
      dec_type1 = ccyc_addr_in[0];
      dec_addr  = '0;
      dec_abort = 1'b0;
      if (dec_type1) begin
         dec_addr = {ccyc_addr_in[31:2], 2'b01};
      end else begin
         // Function and register fields survive, cycle-type bits become 00.
         dec_addr[IDSEL_LO-1:2] = ccyc_addr_in[IDSEL_LO-1:2];
         dec_abort              = ({1'b0, dev} >= 6'(NUM_DEV));
         for (int i = 0; i < NUM_DEV; i++) begin
            if (dev == 5'(i)) begin
               dec_addr[IDSEL_LO+i] = 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // FIFO control
   // ------------------------------------------------------------------
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          valid_q, valid_d;
   logic [31:0]   head_addr_q, head_addr_d;
   logic          head_type1_q, head_type1_d;
   logic          head_abort_q, head_abort_d;
   logic [33:0]   mem_q [DEPTH];
   logic          full;
   logic          push;
   logic          pop;

   // No full-bypass: a full FIFO refuses pushes even when it pops this cycle.
   assign full         = (level_q == LW'(DEPTH));
   assign in_ready_out = ~full & ~flush_in;
   assign push         = in_valid_in & in_ready_out;
   assign pop          = valid_q & out_ready_in & ~flush_in;

   // Next pointers, occupancy and the registered head entry.
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      level_d      = level_q;
      head_addr_d  = head_addr_q;
      head_type1_d = head_type1_q;
      head_abort_d = head_abort_q;
      if (flush_in) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
      end
      // The head register tracks the entry at the new read pointer; when
      // that slot is the one being written now, take it from the decoder.
      // An empty FIFO keeps showing the last head.
      if (level_d != '0) begin
         if (push && (wr_ptr_q == rd_ptr_d)) begin
            head_addr_d  = dec_addr;
            head_type1_d = dec_type1;
            head_abort_d = dec_abort;
         end else begin
            head_addr_d  = mem_q[rd_ptr_d][31:0];
            head_type1_d = mem_q[rd_ptr_d][32];
            head_abort_d = mem_q[rd_ptr_d][33];
         end
      end
      valid_d = (level_d != '0);
   end

   // Storage array; contents are meaningless outside the live window, so no reset.
   always_ff @(posedge clk_in) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {dec_abort, dec_type1, dec_addr};
      end
   end

   // Pointer, level and head state; reset discards every queued entry at once.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         valid_q      <= 1'b0;
         head_addr_q  <= '0;
         head_type1_q <= 1'b0;
         head_abort_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         valid_q      <= valid_d;
         head_addr_q  <= head_addr_d;
         head_type1_q <= head_type1_d;
         head_abort_q <= head_abort_d;
      end
   end

   assign out_valid_out = valid_q;
   assign ccyc_addr_out = head_addr_q;
   assign out_type1_out = head_type1_q;
   assign out_abort_out = head_abort_q;
   assign level_out     = level_q;

`ifdef CCYC_DEC_ABORT_CNT_EN
   // ------------------------------------------------------------------
   // Abort counter: counts aborts as they are accepted, not when popped
   // ------------------------------------------------------------------
   logic [CNT_W-1:0] abort_cnt_q, abort_cnt_d;

   // Clear wins over a same-cycle increment; the count sticks at all-ones.
   always_comb begin
      abort_cnt_d = abort_cnt_q;
      if (abort_cnt_clr_in) begin
         abort_cnt_d = '0;
      end else if (push && dec_abort && (abort_cnt_q != '1)) begin
         abort_cnt_d = abort_cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         abort_cnt_q <= '0;
      end else begin
         abort_cnt_q <= abort_cnt_d;
      end
   end

   assign abort_cnt_out = abort_cnt_q;
`endif

endmodule

// File: tb/tb_pci_conf_cyc_addr_dec_pipe.sv
// tb/tb_pci_conf_cyc_addr_dec_pipe.sv - self-checking bench for pci_conf_cyc_addr_dec_pipe

module tb_pci_conf_cyc_addr_dec_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] addr_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] addr_out;
   logic        type1;
   logic        abort;
   logic [2:0]  level;
`ifdef CCYC_DEC_ABORT_CNT_EN
   logic [15:0] cnt;
   logic        cnt_clr;
   logic [1:0]  sat_cnt;
   logic        sat_in_ready, sat_out_valid, sat_type1, sat_abort;
   logic [31:0] sat_addr_out;
   logic [2:0]  sat_level;
`endif

   always #5 clk = ~clk;

   pci_conf_cyc_addr_dec_pipe #(
      .IDSEL_LO(11), .NUM_DEV(21), .DEPTH(4), .CNT_W(16)
   ) u_dut (
      .clk_in        (clk),
      .reset_n_in    (rst_n),
      .flush_in      (flush),
      .in_valid_in   (in_valid),
      .in_ready_out  (in_ready),
      .ccyc_addr_in  (addr_in),
      .out_valid_out (out_valid),
      .out_ready_in  (out_ready),
      .ccyc_addr_out (addr_out),
      .out_type1_out (type1),
      .out_abort_out (abort),
      .level_out     (level)
`ifdef CCYC_DEC_ABORT_CNT_EN
      ,
      .abort_cnt_out    (cnt),
      .abort_cnt_clr_in (cnt_clr)
`endif
   );

`ifdef CCYC_DEC_ABORT_CNT_EN
   pci_conf_cyc_addr_dec_pipe #(
      .IDSEL_LO(11), .NUM_DEV(21), .DEPTH(4), .CNT_W(2)
   ) u_sat (
      .clk_in           (clk),
      .reset_n_in       (rst_n),
      .flush_in         (flush),
      .in_valid_in      (in_valid),
      .in_ready_out     (sat_in_ready),
      .ccyc_addr_in     (addr_in),
      .out_valid_out    (sat_out_valid),
      .out_ready_in     (out_ready),
      .ccyc_addr_out    (sat_addr_out),
      .out_type1_out    (sat_type1),
      .out_abort_out    (sat_abort),
      .level_out        (sat_level),
      .abort_cnt_out    (sat_cnt),
      .abort_cnt_clr_in (1'b0)
   );
`endif

   typedef struct {
      logic [31:0] addr;
      logic [31:0] exp_addr;
      logic        exp_t1;
      logic        exp_ab;
   } vec_t;

   vec_t vecs [10];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] bp_val(input int k);
      return 32'h0100_0001 + 32'(k) * 32'h100;
   endfunction

   function automatic logic [31:0] wr_val(input int k);
      return 32'h5000_0001 + 32'(k) * 32'h10;
   endfunction

   initial begin
      vecs[0] = '{32'h0000_0000, 32'h0000_0800, 1'b0, 1'b0};
      vecs[1] = '{32'h0000_A000, 32'h8000_0000, 1'b0, 1'b0};
      vecs[2] = '{32'h0000_B004, 32'h0000_0004, 1'b0, 1'b1};
      vecs[3] = '{32'h1234_5679, 32'h1234_5679, 1'b1, 1'b0};
      vecs[4] = '{32'hFFFF_FFFE, 32'h0000_07FC, 1'b0, 1'b1};
      vecs[5] = '{32'h0000_A7FF, 32'h0000_A7FD, 1'b1, 1'b0};
      vecs[6] = '{32'h0000_0806, 32'h0000_1004, 1'b0, 1'b0};
      vecs[7] = '{32'h0000_7800, 32'h0400_0000, 1'b0, 1'b0};
      vecs[8] = '{32'h0000_A800, 32'h0000_0000, 1'b0, 1'b1};
      vecs[9] = '{32'h0000_0003, 32'h0000_0001, 1'b1, 1'b0};

      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      addr_in   = 32'h0;
`ifdef CCYC_DEC_ABORT_CNT_EN
      cnt_clr   = 1'b0;
`endif
      #12;
      chk("rst_level", 32'(level), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_addr", addr_out, 0);
      chk("rst_type1", 32'(type1), 0);
      chk("rst_abort", 32'(abort), 0);
`ifdef CCYC_DEC_ABORT_CNT_EN
      chk("rst_cnt", 32'(cnt), 0);
`endif
      rst_n = 1'b1;
      tick();
      chk("ready_after_reset", 32'(in_ready), 1);

      // Table-driven decode: push one entry, check head, pop, check hold.
      for (int i = 0; i < 10; i++) begin
         addr_in  = vecs[i].addr;
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         chk($sformatf("v%0d_valid", i), 32'(out_valid), 1);
         chk($sformatf("v%0d_addr", i), addr_out, vecs[i].exp_addr);
         chk($sformatf("v%0d_type1", i), 32'(type1), 32'(vecs[i].exp_t1));
         chk($sformatf("v%0d_abort", i), 32'(abort), 32'(vecs[i].exp_ab));
         chk($sformatf("v%0d_level", i), 32'(level), 1);
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         chk($sformatf("v%0d_empty_valid", i), 32'(out_valid), 0);
         chk($sformatf("v%0d_empty_level", i), 32'(level), 0);
         chk($sformatf("v%0d_hold_addr", i), addr_out, vecs[i].exp_addr);
      end

`ifdef CCYC_DEC_ABORT_CNT_EN
      chk("cnt_after_table", 32'(cnt), 3);
      chk("sat_after_table", 32'(sat_cnt), 3);
      addr_in  = 32'h0000_B004;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("cnt_push_edge", 32'(cnt), 4);
      chk("sat_holds", 32'(sat_cnt), 3);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("cnt_no_pop_inc", 32'(cnt), 4);
      in_valid = 1'b1;
      cnt_clr  = 1'b1;
      tick();
      in_valid = 1'b0;
      cnt_clr  = 1'b0;
      chk("cnt_clr_priority", 32'(cnt), 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("cnt_drain_level", 32'(level), 0);
`endif

      // Backpressure: five requests into a 4-deep FIFO with the consumer stalled.
      in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         addr_in = bp_val(k);
         tick();
         chk($sformatf("bp_level_%0d", k), 32'(level), 32'(k + 1));
      end
      chk("bp_ready_low", 32'(in_ready), 0);
      addr_in = bp_val(4);
      tick();
      tick();
      chk("bp_full_level", 32'(level), 4);
      chk("bp_full_head", addr_out, bp_val(0));
      out_ready = 1'b1;
      tick();
      chk("bp_no_bypass_level", 32'(level), 3);
      chk("bp_head1", addr_out, bp_val(1));
      tick();
      in_valid = 1'b0;
      chk("bp_fifth_in_level", 32'(level), 3);
      chk("bp_head2", addr_out, bp_val(2));
      tick();
      chk("bp_head3", addr_out, bp_val(3));
      tick();
      chk("bp_head4", addr_out, bp_val(4));
      chk("bp_level1", 32'(level), 1);
      tick();
      out_ready = 1'b0;
      chk("bp_drained", 32'(out_valid), 0);

      // Steady push/pop at level 2 across pointer wrap.
      in_valid = 1'b1;
      addr_in  = wr_val(0);
      tick();
      addr_in  = wr_val(1);
      tick();
      chk("wrap_prefill", 32'(level), 2);
      out_ready = 1'b1;
      for (int j = 0; j < 10; j++) begin
         addr_in = wr_val(j + 2);
         tick();
         chk($sformatf("wrap_level_%0d", j), 32'(level), 2);
         chk($sformatf("wrap_head_%0d", j), addr_out, wr_val(j + 1));
      end
      in_valid = 1'b0;
      tick();
      chk("wrap_tail_head", addr_out, wr_val(11));
      tick();
      out_ready = 1'b0;
      chk("wrap_drained", 32'(level), 0);

      // Flush at level 3 with a same-cycle pop and an offered push.
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         addr_in = bp_val(k + 8);
         tick();
      end
      chk("flush_prefill", 32'(level), 3);
      flush     = 1'b1;
      out_ready = 1'b1;
      addr_in   = 32'h0000_0003;
      #1;
      chk("flush_ready_low", 32'(in_ready), 0);
      tick();
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("flush_level", 32'(level), 0);
      chk("flush_valid", 32'(out_valid), 0);
      tick();
      chk("flush_stays_empty", 32'(level), 0);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("post_flush_level", 32'(level), 1);
      chk("post_flush_head", addr_out, 32'h0000_0001);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Asynchronous reset mid-stream.
      in_valid = 1'b1;
      addr_in  = 32'h0000_B004;
      tick();
      addr_in  = 32'h1234_5679;
      tick();
      in_valid = 1'b0;
      chk("pre_rst_level", 32'(level), 2);
      chk("pre_rst_abort", 32'(abort), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_level", 32'(level), 0);
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_addr", addr_out, 0);
      chk("mid_rst_type1", 32'(type1), 0);
      chk("mid_rst_abort", 32'(abort), 0);
`ifdef CCYC_DEC_ABORT_CNT_EN
      chk("mid_rst_cnt", 32'(cnt), 0);
`endif
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_level", 32'(level), 0);
      chk("post_rst_ready", 32'(in_ready), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
